// File: rtl/vfd_led_sequencer.sv
// Multi-channel LED pattern sequencer: each channel plays an L-step pattern once per frame.
// Optional brightness PWM is compiled in with `define VFD_SEQ_PWM_EN.
module vfd_led_sequencer #(
    parameter int f_clkin    = 12_000_000,
    parameter int p_frame_hz = 1,
    parameter int p_channels = 4,
    parameter int p_length   = 8,
    parameter logic [p_length-1:0] p_reset_pattern = 'b00000101
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          i_wr_en,
    input  logic [$clog2(p_channels > 1 ? p_channels : 2)-1:0] i_wr_ch,
    input  logic [1:0]                                    i_wr_mode,
    input  logic [p_length-1:0]                           i_wr_pattern,
    input  logic                                          i_sync,
    input  logic [3:0]                                    i_dim,
    output logic [p_channels-1:0]                         o_led,
    output logic [p_channels-1:0]                         o_pending,
    output logic                                          o_frame,
    output logic [$clog2(p_length)-1:0]                   o_step
);

    localparam int P  = f_clkin / (p_frame_hz * p_length);
    localparam int CW = $clog2(p_channels > 1 ? p_channels : 2);
    localparam int SW = $clog2(p_length);
    localparam int PW = $clog2(P > 1 ? P : 2);
    localparam logic [PW-1:0] RELOAD = PW'(P - 1);
    localparam logic [SW-1:0] LAST   = SW'(p_length - 1);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_ON      = 2'b01,
        MODE_LOOP    = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_t;

    logic [PW-1:0]        presc;
    logic [SW-1:0]        step;
    mode_t                act_mode [p_channels];
    logic [p_length-1:0]  act_pat  [p_channels];
    mode_t                sh_mode  [p_channels];
    logic [p_length-1:0]  sh_pat   [p_channels];
    logic [p_channels-1:0] pending;
    logic [p_channels-1:0] led_next;
    logic                 tick;
    logic                 wrap;
    logic                 boundary;
    logic                 pwm_gate;

`ifdef VFD_SEQ_PWM_EN
    logic [3:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign pwm_gate = (pwm_cnt <= i_dim);
`else
    logic dim_unused;

    assign dim_unused = ^i_dim;
    assign pwm_gate   = 1'b1;
`endif

    assign tick     = (presc == '0);
    assign wrap     = tick && (step == LAST);
    assign boundary = wrap || i_sync;

    always_comb begin
        led_next = '0;
        for (int c = 0; c < p_channels; c++) begin
            case (act_mode[c])
                MODE_OFF: led_next[c] = 1'b0;
                MODE_ON:  led_next[c] = pwm_gate;
                default:  led_next[c] = act_pat[c][step] & pwm_gate;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc   <= RELOAD;
            step    <= '0;
            o_frame <= 1'b0;
            o_led   <= '0;
            pending <= '0;
            for (int c = 0; c < p_channels; c++) begin
                act_mode[c] <= MODE_LOOP;
                act_pat[c]  <= p_reset_pattern;
                sh_mode[c]  <= MODE_LOOP;
                sh_pat[c]   <= p_reset_pattern;
            end
        end else begin
            o_led   <= led_next;
            o_frame <= boundary;

            if (i_sync) begin
                presc <= RELOAD;
                step  <= '0;
            end else if (tick) begin
                presc <= RELOAD;
                step  <= wrap ? '0 : step + 1'b1;
            end else begin
                presc <= presc - 1'b1;
            end

            for (int c = 0; c < p_channels; c++) begin
                // A sync restart must not retire a one-shot that has not finished its frame.
                if (boundary && pending[c]) begin
                    act_mode[c] <= sh_mode[c];
                    act_pat[c]  <= sh_pat[c];
                end else if (wrap && !i_sync && act_mode[c] == MODE_ONESHOT) begin
                    act_mode[c] <= MODE_OFF;
                end

                // The write lands in the shadow after the boundary copy, so it waits a frame.
                if (i_wr_en && i_wr_ch == CW'(c)) begin
                    sh_mode[c] <= mode_t'(i_wr_mode);
                    sh_pat[c]  <= i_wr_pattern;
                    pending[c] <= 1'b1;
                end else if (boundary) begin
                    pending[c] <= 1'b0;
                end
            end
        end
    end

    assign o_pending = pending;
    assign o_step    = step;

endmodule

// File: tb/tb_vfd_led_sequencer.sv
// Bench for vfd_led_sequencer: directed vector table, reset sequence and random traffic
// checked against a frame-time reference model (P = 10 clocks per step, 8 steps).
module tb_vfd_led_sequencer;

    localparam int F_CLKIN = 80;
    localparam int FRAME_HZ = 1;
    localparam int CH = 4;
    localparam int L = 8;
    localparam int P = F_CLKIN / (FRAME_HZ * L);

    logic       clk;
    logic       rst_n;
    logic       i_wr_en;
    logic [1:0] i_wr_ch;
    logic [1:0] i_wr_mode;
    logic [7:0] i_wr_pattern;
    logic       i_sync;
    logic [3:0] i_dim;
    logic [3:0] o_led;
    logic [3:0] o_pending;
    logic       o_frame;
    logic [2:0] o_step;

    int checks = 0;
    int errors = 0;

    vfd_led_sequencer #(
        .f_clkin(F_CLKIN),
        .p_frame_hz(FRAME_HZ),
        .p_channels(CH),
        .p_length(L),
        .p_reset_pattern(8'b00000101)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_wr_en(i_wr_en),
        .i_wr_ch(i_wr_ch),
        .i_wr_mode(i_wr_mode),
        .i_wr_pattern(i_wr_pattern),
        .i_sync(i_sync),
        .i_dim(i_dim),
        .o_led(o_led),
        .o_pending(o_pending),
        .o_frame(o_frame),
        .o_step(o_step)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // reference model: k_m counts clocks since the current frame started
    int         k_m;
    int         pwm_m;
    bit         frame_m;
    logic [3:0] led_m;
    logic [3:0] pend_m;
    logic [1:0] mode_m [CH];
    logic [1:0] shm_m  [CH];
    logic [7:0] pat_m  [CH];
    logic [7:0] shp_m  [CH];
    logic [11:0] exp_q[$];

    function automatic bit lit(int c);
        bit on;
        case (mode_m[c])
            2'd0:    on = 1'b0;
            2'd1:    on = 1'b1;
            default: on = pat_m[c][k_m / P];
        endcase
`ifdef VFD_SEQ_PWM_EN
        if ((pwm_m % 16) > int'(i_dim)) on = 1'b0;
`endif
        return on;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [3:0]  led_n;
        logic [11:0] exp_v;
        logic [11:0] act_v;
        bit          wrap_m;
        bit          bnd_m;
        if (!rst_n) begin
            k_m = 0; pwm_m = 0; frame_m = 1'b0; led_m = '0; pend_m = '0;
            for (int c = 0; c < CH; c++) begin
                mode_m[c] = 2'd2; shm_m[c] = 2'd2;
                pat_m[c] = 8'b00000101; shp_m[c] = 8'b00000101;
            end
        end else begin
            for (int c = 0; c < CH; c++) led_n[c] = lit(c);
            wrap_m = (k_m == L * P - 1);
            bnd_m  = wrap_m || i_sync;
            for (int c = 0; c < CH; c++) begin
                if (bnd_m && pend_m[c]) begin
                    mode_m[c] = shm_m[c];
                    pat_m[c]  = shp_m[c];
                end else if (wrap_m && !i_sync && mode_m[c] == 2'd3) begin
                    mode_m[c] = 2'd0;
                end
                if (i_wr_en && int'(i_wr_ch) == c) begin
                    shm_m[c] = i_wr_mode;
                    shp_m[c] = i_wr_pattern;
                    pend_m[c] = 1'b1;
                end else if (bnd_m) begin
                    pend_m[c] = 1'b0;
                end
            end
            k_m = bnd_m ? 0 : k_m + 1;
            frame_m = bnd_m;
            led_m = led_n;
            pwm_m++;
        end
        exp_q.push_back({led_m, pend_m, frame_m, 3'(k_m / P)});
        #1;
        act_v = {o_led, o_pending, o_frame, o_step};
        exp_v = exp_q.pop_front();
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model t=%0t: led=%h pend=%h frame=%b step=%0d, required led=%h pend=%h frame=%b step=%0d",
                     $time, act_v[11:8], act_v[7:4], act_v[3], act_v[2:0],
                     exp_v[11:8], exp_v[7:4], exp_v[3], exp_v[2:0]);
        end
    end

    // directed vectors
    typedef struct {
        string      name;
        int         n;
        bit         wr;
        logic [1:0] ch;
        logic [1:0] mode;
        logic [7:0] pat;
        bit         sync;
        logic [3:0] led;
        logic [3:0] pend;
        logic [2:0] step;
        bit         frame;
    } vec_t;

    function automatic vec_t mk(string nm, int n, bit wr, int ch, int mode, int pat, bit sync,
                                int led, int pend, int step, bit frame);
        vec_t v;
        v.name = nm; v.n = n; v.wr = wr; v.ch = 2'(ch); v.mode = 2'(mode); v.pat = 8'(pat);
        v.sync = sync; v.led = 4'(led); v.pend = 4'(pend); v.step = 3'(step); v.frame = frame;
        return v;
    endfunction

    task automatic check(string name, logic [3:0] led, logic [3:0] pend, logic [2:0] step, logic frame);
        checks++;
        if (o_led !== led || o_pending !== pend || o_step !== step || o_frame !== frame) begin
            errors++;
            $display("FAIL %s: led=%h pend=%h step=%0d frame=%b, required led=%h pend=%h step=%0d frame=%b",
                     name, o_led, o_pending, o_step, o_frame, led, pend, step, frame);
        end
    endtask

    // driver: inputs set at a falling edge, held one cycle, then n edges run
    task automatic run_vec(vec_t v);
        i_wr_en = v.wr; i_wr_ch = v.ch; i_wr_mode = v.mode; i_wr_pattern = v.pat; i_sync = v.sync;
        repeat (v.n) begin
            @(negedge clk);
            i_wr_en = 1'b0;
            i_sync = 1'b0;
        end
        check(v.name, v.led, v.pend, v.step, v.frame);
    endtask

    vec_t vecs[25];

    initial begin
        vecs[0]  = mk("rst_idle",           0, 0, 0, 0, 0,    0, 'h0, 'h0, 0, 0);
        vecs[1]  = mk("first_step",         1, 0, 0, 0, 0,    0, 'hF, 'h0, 0, 0);
        vecs[2]  = mk("first_tick",         9, 0, 0, 0, 0,    0, 'hF, 'h0, 1, 0);
        vecs[3]  = mk("led_lag",            1, 0, 0, 0, 0,    0, 'h0, 'h0, 1, 0);
        vecs[4]  = mk("step2",             10, 0, 0, 0, 0,    0, 'hF, 'h0, 2, 0);
        vecs[5]  = mk("step3",              9, 0, 0, 0, 0,    0, 'hF, 'h0, 3, 0);
        vecs[6]  = mk("wr_ch2_on",          1, 1, 2, 1, 0,    0, 'h0, 'h4, 3, 0);
        vecs[7]  = mk("ch2_held",          48, 0, 0, 0, 0,    0, 'h0, 'h4, 7, 0);
        vecs[8]  = mk("boundary",           1, 0, 0, 0, 0,    0, 'h0, 'h0, 0, 1);
        vecs[9]  = mk("ch2_on",             1, 0, 0, 0, 0,    0, 'hF, 'h0, 0, 0);
        vecs[10] = mk("ch2_const",         10, 0, 0, 0, 0,    0, 'h4, 'h0, 1, 0);
        vecs[11] = mk("wr_ch1_oneshot",     1, 1, 1, 3, 'hFF, 0, 'h4, 'h2, 1, 0);
        vecs[12] = mk("oneshot_apply",     68, 0, 0, 0, 0,    0, 'h4, 'h0, 0, 1);
        vecs[13] = mk("oneshot_play",       1, 0, 0, 0, 0,    0, 'hF, 'h0, 0, 0);
        vecs[14] = mk("oneshot_end",       79, 0, 0, 0, 0,    0, 'h6, 'h0, 0, 1);
        vecs[15] = mk("oneshot_off",        1, 0, 0, 0, 0,    0, 'hD, 'h0, 0, 0);
        vecs[16] = mk("oneshot_stays_off", 20, 0, 0, 0, 0,    0, 'hD, 'h0, 2, 0);
        vecs[17] = mk("pre_wrap",          58, 0, 0, 0, 0,    0, 'h4, 'h0, 7, 0);
        vecs[18] = mk("wr_at_wrap",         1, 1, 3, 1, 0,    0, 'h4, 'h8, 0, 1);
        vecs[19] = mk("late_hold",          1, 0, 0, 0, 0,    0, 'hD, 'h8, 0, 0);
        vecs[20] = mk("late_not_applied",  10, 0, 0, 0, 0,    0, 'h4, 'h8, 1, 0);
        vecs[21] = mk("step5",             39, 0, 0, 0, 0,    0, 'h4, 'h8, 5, 0);
        vecs[22] = mk("sync",               1, 0, 0, 0, 0,    1, 'h4, 'h0, 0, 1);
        vecs[23] = mk("sync_applied",       1, 0, 0, 0, 0,    0, 'hD, 'h0, 0, 0);
        vecs[24] = mk("wr_ch0_off",         1, 1, 0, 0, 0,    0, 'hD, 'h1, 0, 0);

        rst_n = 1'b0; i_wr_en = 1'b0; i_wr_ch = '0; i_wr_mode = '0; i_wr_pattern = '0;
        i_sync = 1'b0; i_dim = 4'd15;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 25; i++) run_vec(vecs[i]);

        // asynchronous reset mid-frame with a write pending
        rst_n = 1'b0;
        #1;
        check("rst_async", 'h0, 'h0, 0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (9) @(negedge clk);
        check("rst_no_tick_yet", 'hF, 'h0, 0, 1'b0);
        @(negedge clk);
        check("rst_first_tick", 'hF, 'h0, 1, 1'b0);

`ifdef VFD_SEQ_PWM_EN
        begin
            int cnt;
            for (int c = 0; c < CH; c++) begin
                i_wr_en = 1'b1; i_wr_ch = 2'(c); i_wr_mode = 2'b01; i_wr_pattern = '0;
                @(negedge clk);
            end
            i_wr_en = 1'b0; i_sync = 1'b1;
            @(negedge clk);
            i_sync = 1'b0; i_dim = 4'd3;
            @(negedge clk);
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (o_led[0]) cnt++;
            end
            checks++;
            if (cnt != 4) begin
                errors++;
                $display("FAIL pwm_dim3: lit %0d of 16, required 4", cnt);
            end
            i_dim = 4'd15;
            @(negedge clk);
            cnt = 0;
            for (int j = 0; j < 16; j++) begin
                @(negedge clk);
                if (o_led[0]) cnt++;
            end
            checks++;
            if (cnt != 16) begin
                errors++;
                $display("FAIL pwm_dim15: lit %0d of 16, required 16", cnt);
            end
        end
`endif

        // random traffic, one reset pulse in the middle
        for (int i = 0; i < 3000; i++) begin
            i_wr_en      = ($urandom_range(0, 3) == 0);
            i_wr_ch      = 2'($urandom_range(0, 3));
            i_wr_mode    = 2'($urandom_range(0, 3));
            i_wr_pattern = 8'($urandom);
            i_sync       = ($urandom_range(0, 59) == 0);
            i_dim        = 4'($urandom_range(0, 15));
            rst_n        = (i != 1500);
            @(negedge clk);
        end
        rst_n = 1'b1; i_wr_en = 1'b0; i_sync = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
